board_writer: RTL

Sequencer that renders an N-queens board into the 128-entry character memory of the display path. It accepts a snapshot of queen column positions from the solver and emits one memory write per cycle, either drawing the board ('Q'/'.' cells) or blanking the whole memory. It is the sole write master of the character memory's we/addr/di port while busy.

---
 rtl/nqueen_pkg.sv | 23 ++
 rtl/board_writer_if.sv | 27 ++
 rtl/cell_counter.sv | 71 +++++++
 rtl/board_writer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/nqueen_pkg.sv
// nqueen_pkg -- constants and types shared by the N-queens display path.
//   CHAR_*     : ASCII codes written into the character memory
//   MEM_DEPTH  : number of character memory entries
//   ADDR_W     : character memory address width
//   state_e    : board_writer sequencer states
package nqueen_pkg;

  localparam int MEM_DEPTH = 128;
  localparam int ADDR_W    = 8;

  localparam logic [7:0] CHAR_Q     = 8'h51;  // 'Q'
  localparam logic [7:0] CHAR_DOT   = 8'h2E;  // '.'
  localparam logic [7:0] CHAR_BLANK = 8'h7E;  // same value as the memory reset fill
  localparam logic [7:0] CHAR_ONE   = 8'h31;  // '1', first row label

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DRAW  = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/board_writer_if.sv
// board_writer_if -- request and character-memory write bus of board_writer.
//   start, clear, pos         : requests from the solver side
//   busy, done                : sequencer status
//   mem_we, mem_addr, mem_di  : character memory write port
// Modports: slave = board_writer, master = requester / memory side.
interface board_writer_if #(
  parameter int N = 8
) ();
  logic             start;
  logic             clear;
  logic [3*N-1:0]   pos;
  logic             busy;
  logic             done;
  logic             mem_we;
  logic [7:0]       mem_addr;
  logic [7:0]       mem_di;

  modport slave (
    input  start, clear, pos,
    output busy, done, mem_we, mem_addr, mem_di
  );

  modport master (
    output start, clear, pos,
    input  busy, done, mem_we, mem_addr, mem_di
  );
endinterface

// File: rtl/cell_counter.sv
// cell_counter -- row/column scan counter.
//   clk, rst       : clock, synchronous active-high reset
//   clr_i          : synchronous restart at (0,0)
//   inc_i          : advance one cell (column inner, row outer)
//   row_last_i     : index of the last row
//   col_last_i     : index of the last column
//   row_nxt_o      : row value after the coming edge
//   col_nxt_o      : column value after the coming edge
//   last_o         : current position is the last cell
// With row_last_i = 0 it behaves as a flat 0..col_last_i counter.
module cell_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] row_last_i,
  input  logic [W-1:0] col_last_i,
  output logic [W-1:0] row_nxt_o,
  output logic [W-1:0] col_nxt_o,
  output logic         last_o
);

  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] row_q, row_d;
  logic [W-1:0] col_q, col_d;

  // Next position: restart, advance with row carry, or hold.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = CNT_ZERO;
      col_d = CNT_ZERO;
    end else if (inc_i) begin
      if (col_q == col_last_i) begin
        col_d = CNT_ZERO;
        if (row_q == row_last_i) begin
          row_d = CNT_ZERO;
        end else begin
          row_d = row_q + CNT_ONE;
        end
      end else begin
        col_d = col_q + CNT_ONE;
        row_d = row_q;
      end
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
  end

  // Position register.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= CNT_ZERO;
      col_q <= CNT_ZERO;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_nxt_o = row_d;
  assign col_nxt_o = col_d;
  assign last_o    = (row_q == row_last_i) && (col_q == col_last_i);

endmodule

// File: rtl/board_writer.sv
// board_writer -- renders an N-queens board (or blanks everything) into the
// 128-entry character memory, one write per cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : board_writer_if.slave
//              start/clear/pos in; busy/done/mem_we/mem_addr/mem_di out
// Parameters: N (board size 1..8), ROW_STRIDE, BASE.
// Optional macro BOARD_WRITER_ROWNUM_EN adds a row label column ('1'+r)
// after the last board column of every row.
module board_writer
  import nqueen_pkg::*;
#(
  parameter int N          = 8,
  parameter int ROW_STRIDE = 16,
  parameter int BASE       = 0
) (
  input  logic         clk,
  input  logic         rst,
  board_writer_if.slave bus
);

`ifdef BOARD_WRITER_ROWNUM_EN
  localparam int W = N + 1;
`else
  localparam int W = N;
`endif

  // One past the highest address ever written by a draw.
  localparam int END_ADDR = BASE + (N - 1) * ROW_STRIDE + W;

  if (N < 1 || N > 8 || BASE < 0 || END_ADDR > MEM_DEPTH) begin : g_bad_cfg
    $error("board_writer: N/BASE/ROW_STRIDE exceed the character memory");
  end

  localparam logic [ADDR_W-1:0] ADDR_ZERO      = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] DRAW_ROW_LAST  = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] DRAW_COL_LAST  = ADDR_W'(W - 1);
  localparam logic [ADDR_W-1:0] CLEAR_COL_LAST = ADDR_W'(MEM_DEPTH - 1);

  state_e            state_q, state_d;
  logic [3*N-1:0]    snap_q, snap_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        di_q, di_d;

  logic              cnt_clr_s, cnt_inc_s, cnt_last_s;
  logic [ADDR_W-1:0] row_last_s, col_last_s, row_nxt_s, col_nxt_s;

  // Character for cell (r, c); a queen column >= N never matches.
  function automatic logic [7:0] cell_char(input logic [3*N-1:0]    snap,
                                           input logic [ADDR_W-1:0] r,
                                           input logic [ADDR_W-1:0] c);
    logic [2:0] q;
    q = 3'd0;
    for (int i = 0; i < N; i++) begin
      q = (ADDR_W'(i) == r) ? snap[3*i +: 3] : q;
    end
    if (int'(c) >= N) begin
      cell_char = CHAR_ONE + r;
    end else if ({5'd0, q} == c) begin
      cell_char = CHAR_Q;
    end else begin
      cell_char = CHAR_DOT;
    end
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ADDR_W-1:0] r,
                                                  input logic [ADDR_W-1:0] c);
    int a;
    a = BASE + int'(r) * ROW_STRIDE + int'(c);
    cell_addr = a[ADDR_W-1:0];
  endfunction

  cell_counter #(
    .W (ADDR_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr_s),
    .inc_i      (cnt_inc_s),
    .row_last_i (row_last_s),
    .col_last_i (col_last_s),
    .row_nxt_o  (row_nxt_s),
    .col_nxt_o  (col_nxt_s),
    .last_o     (cnt_last_s)
  );

  // Sequencer: next state, counter control, next busy/done/we.
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    cnt_clr_s  = 1'b0;
    cnt_inc_s  = 1'b0;
    row_last_s = DRAW_ROW_LAST;
    col_last_s = DRAW_COL_LAST;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    we_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // clear has priority; a simultaneous start is dropped.
        if (bus.clear) begin
          state_d   = ST_CLEAR;
          cnt_clr_s = 1'b1;
          busy_d    = 1'b1;
          we_d      = 1'b1;
        end else if (bus.start) begin
          state_d   = ST_DRAW;
          snap_d    = bus.pos;
          cnt_clr_s = 1'b1;
          busy_d    = 1'b1;
          we_d      = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        row_last_s = ADDR_ZERO;
        col_last_s = CLEAR_COL_LAST;
        if (cnt_last_s) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end else begin
          cnt_inc_s = 1'b1;
          busy_d    = 1'b1;
          we_d      = 1'b1;
        end
      end
      ST_DRAW: begin
        if (cnt_last_s) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end else begin
          cnt_inc_s = 1'b1;
          busy_d    = 1'b1;
          we_d      = 1'b1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Write address/data for the cell the counter moves to at this edge.
  always_comb begin
    addr_d = ADDR_ZERO;
    di_d   = 8'h00;
    if (we_d) begin
      if (state_d == ST_CLEAR) begin
        addr_d = col_nxt_s;
        di_d   = CHAR_BLANK;
      end else begin
        addr_d = cell_addr(row_nxt_s, col_nxt_s);
        di_d   = cell_char(snap_d, row_nxt_s, col_nxt_s);
      end
    end else begin
      addr_d = ADDR_ZERO;
      di_d   = 8'h00;
    end
  end

  // State, snapshot and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      snap_q  <= {(3*N){1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= ADDR_ZERO;
      di_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      di_q    <= di_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.mem_we   = we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_di   = di_q;

endmodule
